// File: rtl/crop_roi_scheduler.sv
// -----------------------------------------------------------------------------
// crop_roi_scheduler
//
// Sequences a downstream crop filter one frame at a time. Region-of-interest
// corners arrive on an AXI-Stream-like port and wait in a small FIFO. For each
// queued ROI the scheduler:
//   1. resets the crop filter for two cycles (FLUSH),
//   2. presents the ROI corner on the Y1 and X1 channels until the filter
//      signals that it has latched each one (LOAD),
//   3. counts accepted input pixels until a full frame has gone through (RUN),
//   4. pulses frame_done and retires the ROI (DONE).
//
// Ports
//   clk             : single clock, rising edge
//   reset           : synchronous, active-high
//   roi_in_TDATA    : ROI corner {Y1, X1}, Y1 in the MSBs
//   roi_in_TVALID   : ROI word valid
//   roi_in_TREADY   : ROI queue has room (combinational from fill level)
//   crop_Y1_TDATA   : Y1 corner to crop filter
//   crop_Y1_TVALID  : Y1 valid (LOAD only)
//   crop_Y1_TREADY  : crop filter Y1 ready
//   crop_X1_TDATA   : X1 corner to crop filter
//   crop_X1_TVALID  : X1 valid (LOAD only)
//   crop_X1_TREADY  : crop filter X1 ready
//   filt_reset      : registered reset to the crop filter
//   pix_beat        : one pixel accepted by the crop filter this cycle
//   frame_done      : one-cycle pulse when a scheduled frame completes
//   busy            : scheduler is not idle
//   beat_err        : sticky, a pixel beat arrived outside RUN
// -----------------------------------------------------------------------------
module crop_roi_scheduler #(
    parameter int IN_ROWS          = 40,
    parameter int IN_COLS          = 40,
    parameter int IMG_ROW_BITWIDTH = 10,
    parameter int IMG_COL_BITWIDTH = 10,
    parameter int FIFO_DEPTH       = 4,
    parameter int BEAT_CNT_W       = 16
) (
    input  logic                                       clk,
    input  logic                                       reset,

    input  logic [IMG_ROW_BITWIDTH+IMG_COL_BITWIDTH-1:0] roi_in_TDATA,
    input  logic                                       roi_in_TVALID,
    output logic                                       roi_in_TREADY,

    output logic [IMG_ROW_BITWIDTH-1:0]                crop_Y1_TDATA,
    output logic                                       crop_Y1_TVALID,
    input  logic                                       crop_Y1_TREADY,

    output logic [IMG_COL_BITWIDTH-1:0]                crop_X1_TDATA,
    output logic                                       crop_X1_TVALID,
    input  logic                                       crop_X1_TREADY,

    output logic                                       filt_reset,
    input  logic                                       pix_beat,
    output logic                                       frame_done,
    output logic                                       busy,
    output logic                                       beat_err
);

    // -------------------------------------------------------------------------
    // Derived constants
    // -------------------------------------------------------------------------
    localparam int ROI_W = IMG_ROW_BITWIDTH + IMG_COL_BITWIDTH;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0]      FIFO_FULL   = CNT_W'(FIFO_DEPTH);
    localparam logic [BEAT_CNT_W-1:0] FRAME_BEATS = BEAT_CNT_W'(IN_ROWS * IN_COLS);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FLUSH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // -------------------------------------------------------------------------
    // ROI queue
    // -------------------------------------------------------------------------
    logic [ROI_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic             push;
    logic             pop;
    logic [ROI_W-1:0] head_roi;

    state_e           state_q, state_d;

    // A full queue deasserts TREADY, so a push can never coincide with a pop
    // while full; pops only happen in DONE, where the head entry exists.
    assign roi_in_TREADY = (count_q != FIFO_FULL);
    assign push          = roi_in_TVALID && roi_in_TREADY;
    assign pop           = (state_q == ST_DONE) && (count_q != '0);
    assign head_roi      = fifo_mem[rd_ptr_q];

    // NOTE: every always_comb output gets a default before any branch, so no
    // path through the block leaves a value unassigned and no latch appears.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        // Depth is a power of two, so pointers wrap by plain overflow.
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: the storage array is deliberately left out of reset; the pointers
    // and fill count define which entries are meaningful, and an unreset
    // array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= roi_in_TDATA;
        end
    end

    // -------------------------------------------------------------------------
    // Frame scheduler FSM
    // -------------------------------------------------------------------------
    logic                  flush_cnt_q,  flush_cnt_d;
    logic [BEAT_CNT_W-1:0] beat_cnt_q,   beat_cnt_d;
    logic                  y_pend_q,     y_pend_d;
    logic                  x_pend_q,     x_pend_d;
    logic                  beat_err_q,   beat_err_d;
    logic                  filt_reset_q, filt_reset_d;

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        y_pend_d    = y_pend_q;
        x_pend_d    = x_pend_q;

        // Beats are only meaningful while a frame is running; anywhere else
        // they are flagged and otherwise dropped.
        beat_err_d  = beat_err_q || (pix_beat && (state_q != ST_RUN));

        unique case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = 1'b0;
                end
            end

            ST_FLUSH: begin
                // Two-cycle filter reset; arm both corner channels for LOAD.
                beat_cnt_d = '0;
                y_pend_d   = 1'b1;
                x_pend_d   = 1'b1;
                if (flush_cnt_q) begin
                    state_d = ST_LOAD;
                end else begin
                    flush_cnt_d = 1'b1;
                end
            end

            ST_LOAD: begin
                // The filter signals it has latched a corner by pulling its
                // TREADY low; each channel retires independently.
                if (y_pend_q && !crop_Y1_TREADY) begin
                    y_pend_d = 1'b0;
                end
                if (x_pend_q && !crop_X1_TREADY) begin
                    x_pend_d = 1'b0;
                end
                if (!y_pend_d && !x_pend_d) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                // The frame ends exactly on the last beat, so the counter
                // never reaches a value that could wrap.
                if (pix_beat) begin
                    beat_cnt_d = beat_cnt_q + BEAT_CNT_W'(1);
                    if (beat_cnt_d == FRAME_BEATS) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered so the filter sees a glitch-free reset that lines up
        // with the FLUSH cycles.
        filt_reset_d = (state_d == ST_FLUSH);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            flush_cnt_q  <= 1'b0;
            beat_cnt_q   <= '0;
            y_pend_q     <= 1'b0;
            x_pend_q     <= 1'b0;
            beat_err_q   <= 1'b0;
            filt_reset_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            flush_cnt_q  <= flush_cnt_d;
            beat_cnt_q   <= beat_cnt_d;
            y_pend_q     <= y_pend_d;
            x_pend_q     <= x_pend_d;
            beat_err_q   <= beat_err_d;
            filt_reset_q <= filt_reset_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // Corner data is only driven while it is being offered; zero otherwise
    // keeps stale queue contents off the filter interface.
    assign crop_Y1_TVALID = (state_q == ST_LOAD) && y_pend_q;
    assign crop_X1_TVALID = (state_q == ST_LOAD) && x_pend_q;
    assign crop_Y1_TDATA  = (state_q == ST_LOAD) ? head_roi[ROI_W-1 -: IMG_ROW_BITWIDTH] : '0;
    assign crop_X1_TDATA  = (state_q == ST_LOAD) ? head_roi[IMG_COL_BITWIDTH-1:0] : '0;

    assign filt_reset     = filt_reset_q;
    assign frame_done     = (state_q == ST_DONE);
    assign busy           = (state_q != ST_IDLE);
    assign beat_err       = beat_err_q;

endmodule

// File: tb/tb_crop_roi_scheduler.sv
// -----------------------------------------------------------------------------
// Self-checking bench for crop_roi_scheduler. A reference model holds the ROI
// queue as an SV queue and derives the expected filter-side timing directly
// from the handshake rules: a corner stays valid up to and including the
// cycle its TREADY is low, RUN starts once both are gone, and a frame is
// IN_ROWS*IN_COLS RUN beats long.
// -----------------------------------------------------------------------------
module tb_crop_roi_scheduler;

    localparam int ROW_W = 10;
    localparam int COL_W = 10;
    localparam int ROWS  = 40;
    localparam int COLS  = 40;
    localparam int DEPTH = 4;
    localparam int FRAME = ROWS * COLS;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [ROW_W+COL_W-1:0] roi_in_TDATA;
    logic                   roi_in_TVALID;
    logic                   roi_in_TREADY;
    logic [ROW_W-1:0]       crop_Y1_TDATA;
    logic                   crop_Y1_TVALID;
    logic                   crop_Y1_TREADY;
    logic [COL_W-1:0]       crop_X1_TDATA;
    logic                   crop_X1_TVALID;
    logic                   crop_X1_TREADY;
    logic                   filt_reset;
    logic                   pix_beat;
    logic                   frame_done;
    logic                   busy;
    logic                   beat_err;

    int vectors     = 0;
    int miscompares = 0;

    logic [ROW_W+COL_W-1:0] model_q[$];
    logic                   model_err;
    int                     done_count;

    crop_roi_scheduler #(
        .IN_ROWS          (ROWS),
        .IN_COLS          (COLS),
        .IMG_ROW_BITWIDTH (ROW_W),
        .IMG_COL_BITWIDTH (COL_W),
        .FIFO_DEPTH       (DEPTH),
        .BEAT_CNT_W       (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .roi_in_TDATA   (roi_in_TDATA),
        .roi_in_TVALID  (roi_in_TVALID),
        .roi_in_TREADY  (roi_in_TREADY),
        .crop_Y1_TDATA  (crop_Y1_TDATA),
        .crop_Y1_TVALID (crop_Y1_TVALID),
        .crop_Y1_TREADY (crop_Y1_TREADY),
        .crop_X1_TDATA  (crop_X1_TDATA),
        .crop_X1_TVALID (crop_X1_TVALID),
        .crop_X1_TREADY (crop_X1_TREADY),
        .filt_reset     (filt_reset),
        .pix_beat       (pix_beat),
        .frame_done     (frame_done),
        .busy           (busy),
        .beat_err       (beat_err)
    );

    always #5 clk = ~clk;

    initial begin
        #(10 * 80000);
        $display("FAIL watchdog: simulation still running after 80000 cycles");
        $fatal(1);
    end

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hard_reset();
        reset          = 1'b1;
        roi_in_TVALID  = 1'b0;
        pix_beat       = 1'b0;
        crop_Y1_TREADY = 1'b1;
        crop_X1_TREADY = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        model_q.delete();
        model_err  = 1'b0;
        done_count = 0;
    endtask

    task automatic push_roi(input logic [ROW_W+COL_W-1:0] roi);
        bit accepted;
        accepted      = 1'b0;
        roi_in_TDATA  = roi;
        roi_in_TVALID = 1'b1;
        for (int t = 0; t < 6000; t++) begin
            if (roi_in_TREADY === 1'b1) begin
                accepted = 1'b1;
                break;
            end
            tick();
        end
        if (accepted) begin
            tick();
            model_q.push_back(roi);
        end
        roi_in_TVALID = 1'b0;
        vectors++;
        if (!accepted) begin
            miscompares++;
            $display("FAIL push_timeout: roi_in_TREADY got 0 for 6000 cycles, want 1");
        end
    endtask

    // Runs one scheduled frame from FLUSH to the idle cycle after DONE.
    // dy/dx: LOAD cycle index at which each channel's TREADY goes low.
    // err_k: LOAD cycle in which a stray pix_beat is injected (-1 = none).
    // abort_at: reset after this many RUN beats (0 = run to completion).
    task automatic run_frame(input int dy, input int dx, input int err_k, input int abort_at);
        bit                     ok;
        int                     n;
        int                     last;
        int                     bad;
        logic [ROW_W+COL_W-1:0] exp_roi;
        logic                   exp_vy, exp_vx;

        crop_Y1_TREADY = 1'b1;
        crop_X1_TREADY = 1'b1;
        pix_beat       = 1'b0;

        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            if (filt_reset === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL flush_start: filt_reset got 0 for 200 cycles, want 1");
            return;
        end

        n   = 0;
        bad = 0;
        while (filt_reset === 1'b1 && n < 10) begin
            if (crop_Y1_TVALID !== 1'b0 || crop_X1_TVALID !== 1'b0 || busy !== 1'b1) bad++;
            n++;
            tick();
        end
        vectors++;
        if (n != 2) begin
            miscompares++;
            $display("FAIL flush_len: filt_reset high for %0d cycles, want 2", n);
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL flush_outputs: %0d cycles with TVALID high or busy low, want 0", bad);
        end

        if (model_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL model_empty: frame started with 0 queued ROIs, want >=1");
            return;
        end
        exp_roi = model_q[0];

        last = ((dy > dx) ? dy : dx) + 1;
        for (int k = 0; k <= last; k++) begin
            crop_Y1_TREADY = (k < dy);
            crop_X1_TREADY = (k < dx);
            pix_beat       = (k == err_k);
            exp_vy         = (k <= dy);
            exp_vx         = (k <= dx);
            vectors++;
            if (crop_Y1_TVALID !== exp_vy) begin
                miscompares++;
                $display("FAIL load_y_valid k=%0d: got %b, want %b", k, crop_Y1_TVALID, exp_vy);
            end
            vectors++;
            if (crop_X1_TVALID !== exp_vx) begin
                miscompares++;
                $display("FAIL load_x_valid k=%0d: got %b, want %b", k, crop_X1_TVALID, exp_vx);
            end
            if (exp_vy) begin
                vectors++;
                if (crop_Y1_TDATA !== exp_roi[ROW_W+COL_W-1:COL_W]) begin
                    miscompares++;
                    $display("FAIL load_y_data k=%0d: got %0d, want %0d", k, crop_Y1_TDATA,
                             exp_roi[ROW_W+COL_W-1:COL_W]);
                end
            end
            if (exp_vx) begin
                vectors++;
                if (crop_X1_TDATA !== exp_roi[COL_W-1:0]) begin
                    miscompares++;
                    $display("FAIL load_x_data k=%0d: got %0d, want %0d", k, crop_X1_TDATA,
                             exp_roi[COL_W-1:0]);
                end
            end
            if (k < last) tick();
        end
        pix_beat       = 1'b0;
        crop_Y1_TREADY = 1'b1;
        crop_X1_TREADY = 1'b1;
        if (err_k >= 0 && err_k < last) model_err = 1'b1;

        bad = 0;
        for (int b = 0; b < FRAME; b++) begin
            if (abort_at > 0 && b == abort_at) begin
                pix_beat = 1'b0;
                reset    = 1'b1;
                tick();
                model_q.delete();
                model_err = 1'b0;
                vectors++;
                if (filt_reset !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0 ||
                    crop_Y1_TVALID !== 1'b0 || crop_X1_TVALID !== 1'b0 || beat_err !== 1'b0) begin
                    miscompares++;
                    $display("FAIL abort_reset: filt_reset/busy/done/vy/vx/err got %b%b%b%b%b%b, want 100000",
                             filt_reset, busy, frame_done, crop_Y1_TVALID, crop_X1_TVALID, beat_err);
                end
                vectors++;
                if (roi_in_TREADY !== 1'b1) begin
                    miscompares++;
                    $display("FAIL abort_queue: roi_in_TREADY got %b, want 1", roi_in_TREADY);
                end
                reset = 1'b0;
                for (int t = 0; t < 8; t++) begin
                    tick();
                    if (busy !== 1'b0 || frame_done !== 1'b0 || filt_reset !== 1'b0) bad++;
                end
                vectors++;
                if (bad != 0) begin
                    miscompares++;
                    $display("FAIL abort_idle: %0d cycles busy/done/filt_reset high after reset, want 0", bad);
                end
                return;
            end
            if ($urandom_range(7) == 0) begin
                pix_beat = 1'b0;
                tick();
                if (frame_done !== 1'b0 || busy !== 1'b1) bad++;
            end
            pix_beat = 1'b1;
            tick();
            if (b < FRAME - 1 && (frame_done !== 1'b0 || busy !== 1'b1)) bad++;
        end
        pix_beat = 1'b0;

        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL run_early: %0d RUN cycles with frame_done high or busy low, want 0", bad);
        end
        vectors++;
        if (frame_done !== 1'b1) begin
            miscompares++;
            $display("FAIL frame_done: got %b after beat %0d, want 1", frame_done, FRAME);
        end
        vectors++;
        if (beat_err !== model_err) begin
            miscompares++;
            $display("FAIL beat_err_frame: got %b, want %b", beat_err, model_err);
        end
        done_count++;
        void'(model_q.pop_front());
        tick();
        vectors++;
        if (frame_done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL after_done: frame_done/busy got %b%b, want 00", frame_done, busy);
        end
    endtask

    function automatic logic [ROW_W+COL_W-1:0] rand_roi();
        logic [ROW_W-1:0] y;
        logic [COL_W-1:0] x;
        y = ROW_W'($urandom_range(ROWS - 1));
        x = COL_W'($urandom_range(COLS - 1));
        return {y, x};
    endfunction

    // -------------------------------------------------------------------------
    task automatic test_reset();
        reset          = 1'b1;
        roi_in_TVALID  = 1'b0;
        roi_in_TDATA   = '0;
        pix_beat       = 1'b0;
        crop_Y1_TREADY = 1'b1;
        crop_X1_TREADY = 1'b1;
        tick();
        tick();
        tick();
        vectors++;
        if (filt_reset !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_filt_reset: got %b, want 1", filt_reset);
        end
        vectors++;
        if (busy !== 1'b0 || frame_done !== 1'b0 || beat_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_status: busy/done/err got %b%b%b, want 000", busy, frame_done, beat_err);
        end
        vectors++;
        if (crop_Y1_TVALID !== 1'b0 || crop_X1_TVALID !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_valid: vy/vx got %b%b, want 00", crop_Y1_TVALID, crop_X1_TVALID);
        end
        reset = 1'b0;
        tick();
        vectors++;
        if (roi_in_TREADY !== 1'b1 || filt_reset !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset: tready/filt_reset got %b%b, want 10", roi_in_TREADY, filt_reset);
        end
        tick();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_empty: busy got %b, want 0", busy);
        end
        model_q.delete();
        model_err  = 1'b0;
        done_count = 0;
    endtask

    task automatic test_basic_frame();
        push_roi({10'd10, 10'd5});
        run_frame(2, 2, -1, 0);
        for (int i = 0; i < 2; i++) begin
            push_roi(rand_roi());
            run_frame(int'($urandom_range(4)), int'($urandom_range(4)), -1, 0);
        end
    endtask

    task automatic test_fifo_full();
        hard_reset();
        fork
            begin
                for (int i = 0; i < DEPTH; i++) push_roi(rand_roi());
                vectors++;
                if (roi_in_TREADY !== 1'b0 || done_count != 0) begin
                    miscompares++;
                    $display("FAIL fifo_full: tready got %b with %0d frames done, want 0 with 0",
                             roi_in_TREADY, done_count);
                end
                push_roi(rand_roi());
                vectors++;
                if (done_count != 1) begin
                    miscompares++;
                    $display("FAIL fifo_stall: 5th ROI accepted after %0d frames, want 1", done_count);
                end
            end
            begin
                for (int f = 0; f < DEPTH + 1; f++) begin
                    run_frame(int'($urandom_range(3)), int'($urandom_range(3)), -1, 0);
                end
            end
        join
        vectors++;
        if (done_count != DEPTH + 1 || model_q.size() != 0) begin
            miscompares++;
            $display("FAIL fifo_drain: %0d frames done, %0d left, want %0d and 0",
                     done_count, model_q.size(), DEPTH + 1);
        end
    endtask

    task automatic test_split_ready();
        push_roi(rand_roi());
        run_frame(0, 3, -1, 0);
        push_roi(rand_roi());
        run_frame(4, 1, -1, 0);
    endtask

    task automatic test_beat_err();
        hard_reset();
        push_roi(rand_roi());
        run_frame(1, 4, 2, 0);
        tick();
        tick();
        vectors++;
        if (beat_err !== 1'b1) begin
            miscompares++;
            $display("FAIL beat_err_sticky: got %b, want 1", beat_err);
        end
        reset = 1'b1;
        tick();
        vectors++;
        if (beat_err !== 1'b0) begin
            miscompares++;
            $display("FAIL beat_err_clear: got %b, want 0", beat_err);
        end
        reset = 1'b0;
        tick();
        pix_beat = 1'b1;
        tick();
        pix_beat = 1'b0;
        vectors++;
        if (beat_err !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL beat_err_idle: err/busy got %b%b, want 10", beat_err, busy);
        end
        hard_reset();
    endtask

    task automatic test_reset_mid_frame();
        hard_reset();
        fork
            begin
                for (int i = 0; i < 3; i++) push_roi(rand_roi());
            end
            begin
                run_frame(1, 1, -1, 800);
            end
        join
        vectors++;
        if (done_count != 0) begin
            miscompares++;
            $display("FAIL abort_no_done: %0d frames completed, want 0", done_count);
        end
    endtask

    initial begin
        model_err  = 1'b0;
        done_count = 0;
        test_reset();
        test_basic_frame();
        test_fifo_full();
        test_split_ready();
        test_beat_err();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
